nco_tone_sequencer: RTL and testbench
=====================================

NCO_TONE_SEQUENCER -- requirements
Module: nco_tone_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have cfg_we input 1, cfg_addr input 3, cfg_phi input 32: tone-table write port (entry cfg_addr <- cfg_phi).
REQ-004 SHALL have num_tones input 4 (tones per sweep) and dwell input 16 (samples per tone).
REQ-005 SHALL have start input 1, abort input 1, busy output 1, done output 1 (one-cycle pulse).
REQ-006 SHALL have nco_phi_inc_o output 32, nco_clken_o output 1, nco_reset_n_o output 1: drive NCO phi_inc_i/clken/reset_n.
REQ-007 SHALL have nco_valid_i input 1, nco_sin_i input 10, nco_cos_i input 10: NCO out_valid/fsin_o/fcos_o.
REQ-008 SHALL have out_valid output 1, out_ready input 1, out_sin output 10, out_cos output 10, out_tone output 3, out_last output 1: sample stream.

Function
REQ-009 SHALL hold an 8 x 32-bit tone table, written on cfg_we=1 only in IDLE; writes elsewhere ignored.
REQ-010 SHALL implement states IDLE, FLUSH, RUN, DRAIN.
REQ-011 IDLE: start=1 latches num_tones (0 -> 1, >8 -> 8) and dwell (0 -> 1), tone index=0, sample count=0, enters FLUSH.
REQ-012 FLUSH: nco_reset_n_o=0 for exactly 2 cycles (zeroing NCO accumulator), then RUN; nco_reset_n_o=1 in all other states.
REQ-013 nco_phi_inc_o SHALL equal table[tone index] combinationally-registered, updated the cycle the index changes; table[0] in IDLE.
REQ-014 nco_clken_o SHALL be 1 only in RUN and when (out_valid=0 or out_ready=1); NCO pipeline stalls otherwise.
REQ-015 A sample SHALL be captured on a rising edge with nco_clken_o=1 and nco_valid_i=1: out_sin/out_cos <- inputs, out_tone <- index, out_valid <- 1.
REQ-016 out_valid SHALL stay 1 with data stable until out_valid & out_ready; simultaneous capture and accept replaces data, out_valid stays 1.
REQ-017 Each capture increments sample count; at count=dwell-1 count wraps to 0 and index increments; tone change is phase-continuous (no NCO reset).
REQ-018 Capture of sample dwell-1 of tone num_tones-1 SHALL set out_last=1 with that sample and enter DRAIN; out_last=0 on all other samples.
REQ-019 DRAIN: nco_clken_o=0; on out_valid & out_ready, done=1 for one cycle, enter IDLE.
REQ-020 busy SHALL be 1 in FLUSH, RUN, DRAIN; 0 in IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 abort=1 in any non-IDLE state SHALL enter IDLE next cycle, clear out_valid and out_last, drop nco_clken_o, no done pulse; abort has priority over start and capture.
REQ-023 Total samples per sweep SHALL equal num_tones x dwell (after clamping), no loss or duplication under any out_ready pattern.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, out_valid=0, out_last=0, out_sin=out_cos=0, out_tone=0, nco_clken_o=0, nco_reset_n_o=0, index/count=0.
REQ-025 Tone table SHALL reset to all zero; nco_reset_n_o returns to 1 on first clock after reset release.
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.

Verification
REQ-027 Table {0x0CCCCCCD, 0x19999999}, num_tones=2, dwell=4, out_ready=1, NCO model latency 3 -> 8 samples, out_tone 0,0,0,0,1,1,1,1, out_last on 8th, one done pulse.
REQ-028 Same sweep, out_ready toggling 1-of-3 cycles -> identical 8-sample sequence as REQ-027, out_sin/out_cos stable while stalled, nco_clken_o=0 during stalls.
REQ-029 num_tones=0, dwell=0 -> exactly 1 sample, tone 0, out_last=1, done pulse.
REQ-030 abort in RUN after 3 samples -> IDLE next cycle, out_valid=0, no done; subsequent start runs full sweep.
REQ-031 cfg_we to addr 1 during RUN, start while busy -> table unchanged, sweep unaffected.
REQ-032 reset_n low mid-RUN -> all outputs to REQ-024 values same cycle; table reads zero afterward.

Source files
------------

// File: rtl/nco_tone_sequencer_if.sv
// Sample stream from the tone sequencer to its consumer.
// master: sequencer side (drives sample fields, samples out_ready)
// slave : consumer side (samples fields, drives out_ready)
//   out_valid  sample present
//   out_ready  consumer accepts the sample on this edge
//   out_sin    10-bit sine sample
//   out_cos    10-bit cosine sample
//   out_tone   tone-table index the sample belongs to
//   out_last   final sample of the sweep
interface nco_tone_sequencer_if;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sin;
    logic [9:0] out_cos;
    logic [2:0] out_tone;
    logic       out_last;

    modport master (
        output out_valid, out_sin, out_cos, out_tone, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_sin, out_cos, out_tone, out_last,
        output out_ready
    );
endinterface

// File: rtl/nco_tone_sequencer.sv
// Steps an external NCO through a programmable table of phase increments,
// dwelling a fixed number of samples on each tone, and forwards the NCO
// samples as a valid/ready stream tagged with tone index and last flag.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_phi    tone-table write port (accepted only when idle)
//   num_tones, dwell           sweep length (tones) and samples per tone
//   start, abort               sweep control
//   busy, done                 sweep status, done is a one-cycle pulse
//   nco_phi_inc_o/clken_o/
//   nco_reset_n_o              drive the NCO increment, clock enable, reset
//   nco_valid_i/sin_i/cos_i    NCO output samples
//   smp                        sample stream (master side)
module nco_tone_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_phi,
    input  logic [3:0]  num_tones,
    input  logic [15:0] dwell,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] nco_phi_inc_o,
    output logic        nco_clken_o,
    output logic        nco_reset_n_o,
    input  logic        nco_valid_i,
    input  logic [9:0]  nco_sin_i,
    input  logic [9:0]  nco_cos_i,
    nco_tone_sequencer_if.master smp
);
    localparam int unsigned TBL_DEPTH = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned PHI_W     = 32;
    localparam int unsigned SMP_W     = 10;
    localparam int unsigned DWELL_W   = 16;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN} state_t;

    state_t               r_state;
    logic [PHI_W-1:0]     r_table [TBL_DEPTH];
    logic [IDX_W-1:0]     r_last_idx;
    logic [DWELL_W-1:0]   r_dwell_m1;
    logic [IDX_W-1:0]     r_idx;
    logic [DWELL_W-1:0]   r_cnt;
    logic                 r_flush;
    logic [PHI_W-1:0]     r_phi;
    logic                 r_nco_rst_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic                 r_last;
    logic [SMP_W-1:0]     r_sin;
    logic [SMP_W-1:0]     r_cos;
    logic [IDX_W-1:0]     r_tone;

    logic [IDX_W-1:0]     w_nt_m1;
    logic [DWELL_W-1:0]   w_dwell_m1;
    logic                 w_clken;
    logic                 w_cap;
    logic                 w_accept;
    logic                 w_tone_end;
    logic                 w_sweep_end;
    logic [PHI_W-1:0]     w_phi0;

    // Clamp sweep parameters: 0 tones -> 1, >8 tones -> 8, 0 dwell -> 1
    assign w_nt_m1    = (num_tones == 4'd0) ? IDX_W'(0) :
                        (num_tones > 4'd8)  ? IDX_W'(TBL_DEPTH - 1) :
                                              IDX_W'(num_tones - 4'd1);
    assign w_dwell_m1 = (dwell == 16'd0) ? 16'd0 : dwell - 16'd1;

    // NCO advances only while the output register can take a new sample
    assign w_clken     = (r_state == S_RUN) && (!r_valid || smp.out_ready);
    assign w_cap       = w_clken && nco_valid_i;
    assign w_accept    = r_valid && smp.out_ready;
    assign w_tone_end  = (r_cnt == r_dwell_m1);
    assign w_sweep_end = w_tone_end && (r_idx == r_last_idx);

    // Entry 0 as it will read after this cycle's table write
    assign w_phi0 = (cfg_we && cfg_addr == IDX_W'(0)) ? cfg_phi : r_table[0];

    // Sequencer state, tone table and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last_idx  <= '0;
            r_dwell_m1  <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_flush     <= 1'b0;
            r_phi       <= '0;
            r_nco_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_sin       <= '0;
            r_cos       <= '0;
            r_tone      <= '0;
            for (int i = 0; i < TBL_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                // Abandon sweep without a done pulse; pending sample dropped
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_valid     <= 1'b0;
                r_last      <= 1'b0;
                r_nco_rst_n <= 1'b1;
                r_idx       <= '0;
                r_cnt       <= '0;
                r_phi       <= r_table[0];
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_nco_rst_n <= 1'b1;
                        r_phi       <= w_phi0;
                        if (cfg_we) begin
                            r_table[cfg_addr] <= cfg_phi;
                        end
                        if (start) begin
                            r_last_idx  <= w_nt_m1;
                            r_dwell_m1  <= w_dwell_m1;
                            r_idx       <= '0;
                            r_cnt       <= '0;
                            r_flush     <= 1'b0;
                            r_nco_rst_n <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        // Hold NCO reset for two cycles to clear its accumulator
                        if (r_flush) begin
                            r_nco_rst_n <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_flush <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_cap) begin
                            r_sin   <= nco_sin_i;
                            r_cos   <= nco_cos_i;
                            r_tone  <= r_idx;
                            r_valid <= 1'b1;
                            r_last  <= w_sweep_end;
                            if (w_sweep_end) begin
                                r_state <= S_DRAIN;
                            end else if (w_tone_end) begin
                                // Phase-continuous tone change: no NCO reset
                                r_cnt <= '0;
                                r_idx <= r_idx + IDX_W'(1);
                                r_phi <= r_table[r_idx + IDX_W'(1)];
                            end else begin
                                r_cnt <= r_cnt + DWELL_W'(1);
                            end
                        end else if (w_accept) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        if (w_accept) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                            r_cnt   <= '0;
                            r_phi   <= r_table[0];
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign nco_phi_inc_o = r_phi;
    assign nco_clken_o   = w_clken;
    assign nco_reset_n_o = r_nco_rst_n;

    assign smp.out_valid = r_valid;
    assign smp.out_sin   = r_sin;
    assign smp.out_cos   = r_cos;
    assign smp.out_tone  = r_tone;
    assign smp.out_last  = r_last;
endmodule

// File: tb/tb_nco_tone_sequencer.sv
// Bench for nco_tone_sequencer: a 3-stage NCO model feeds the DUT, a
// negedge monitor collects accepted samples and checks stall behaviour.
module tb_nco_tone_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_phi = '0;
    logic [3:0]  num_tones = '0;
    logic [15:0] dwell = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] nco_phi_inc_o;
    logic        nco_clken_o, nco_reset_n_o;
    logic        nco_valid_i;
    logic [9:0]  nco_sin_i, nco_cos_i;

    nco_tone_sequencer_if smp();

    nco_tone_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_phi(cfg_phi),
        .num_tones(num_tones), .dwell(dwell),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .nco_phi_inc_o(nco_phi_inc_o), .nco_clken_o(nco_clken_o),
        .nco_reset_n_o(nco_reset_n_o),
        .nco_valid_i(nco_valid_i), .nco_sin_i(nco_sin_i), .nco_cos_i(nco_cos_i),
        .smp(smp)
    );

    always #5 clk = ~clk;

    // NCO model: accumulator plus 3-stage output pipeline, all gated by clken
    logic [31:0] m_acc, m_p1, m_p2, m_p3;
    logic [2:0]  m_v;
    always_ff @(posedge clk) begin
        if (!nco_reset_n_o) begin
            m_acc <= '0; m_p1 <= '0; m_p2 <= '0; m_p3 <= '0; m_v <= '0;
        end else if (nco_clken_o) begin
            m_acc <= m_acc + nco_phi_inc_o;
            m_p1  <= m_acc;
            m_p2  <= m_p1;
            m_p3  <= m_p2;
            m_v   <= {m_v[1:0], 1'b1};
        end
    end
    assign nco_valid_i = m_v[2];
    assign nco_sin_i   = m_p3[31:22];
    assign nco_cos_i   = ~m_p3[31:22];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    logic [31:0] tb_tab [8];
    initial begin
        tb_tab[0] = 32'h0CCCCCCD; tb_tab[1] = 32'h19999999;
        tb_tab[2] = 32'h01234567; tb_tab[3] = 32'h2468ACE0;
        tb_tab[4] = 32'h00F00F00; tb_tab[5] = 32'h33333333;
        tb_tab[6] = 32'h05555555; tb_tab[7] = 32'h7FFFFFFF;
    end

    // Ready pattern: 0 always ready, 1 ready one cycle in three, 2 never
    int rmode = 0;
    int rph   = 0;
    initial smp.out_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       smp.out_ready = 1'b1;
            1:       smp.out_ready = (rph == 0);
            default: smp.out_ready = 1'b0;
        endcase
        rph = (rph + 1) % 3;
    end

    // Monitor: collect accepted samples, check stalled data is held
    logic [23:0] got_q [$];
    int          done_cnt = 0;
    logic        mon_en = 1'b0;
    logic        stall_pend = 1'b0;
    logic [23:0] held;
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (stall_pend)
                check("stall_hold", {smp.out_valid, smp.out_tone, smp.out_last,
                                     smp.out_sin, smp.out_cos}, {1'b1, held});
            if (smp.out_valid && !smp.out_ready) begin
                check("stall_clken", nco_clken_o, 1'b0);
                stall_pend = 1'b1;
                held = {smp.out_tone, smp.out_last, smp.out_sin, smp.out_cos};
            end else begin
                stall_pend = 1'b0;
            end
            if (smp.out_valid && smp.out_ready)
                got_q.push_back({smp.out_tone, smp.out_last, smp.out_sin, smp.out_cos});
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_sweep(input logic [3:0] nt, input logic [15:0] dw, input int rm);
        num_tones = nt; dwell = dw; rmode = rm;
        got_q.delete(); done_cnt = 0; stall_pend = 1'b0; mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        check({nm, "_finished"}, (done_cnt > 0), 1'b1);
        repeat (4) tick();
        check({nm, "_idle"}, busy, 1'b0);
    endtask

    // Expected phase of sample k: increments applied on clken edges 1..k,
    // the increment on edge j being that of the tone active at that edge
    function automatic logic [31:0] exp_phase(input int k, input int d, input int nt);
        logic [31:0] acc;
        int idx;
        acc = '0;
        for (int j = 1; j <= k; j++) begin
            idx = (j < 4) ? 0 : (j - 4) / d;
            if (idx > nt - 1) idx = nt - 1;
            acc = acc + tb_tab[idx];
        end
        return acc;
    endfunction

    task automatic check_sweep(input string nm, input int ent, input int edw, input int exp_n);
        logic [31:0] ph;
        logic [23:0] ex;
        logic [9:0]  s;
        logic [2:0]  t;
        check({nm, "_count"}, got_q.size(), exp_n);
        check({nm, "_done"}, done_cnt, 1);
        for (int k = 0; k < got_q.size() && k < exp_n; k++) begin
            ph = exp_phase(k, edw, ent);
            s  = ph[31:22];
            t  = 3'(k / edw);
            ex = {t, (k == exp_n - 1), s, ~s};
            check($sformatf("%s_smp%0d", nm, k), got_q[k], ex);
        end
    endtask

    typedef struct {
        logic [3:0]  nt;
        logic [15:0] dw;
        int          rm;
        int          ent;
        int          edw;
        int          exp_n;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int n;
        vecs[0] = '{4'd2,  16'd4, 0, 2, 4, 8};
        vecs[1] = '{4'd2,  16'd4, 1, 2, 4, 8};
        vecs[2] = '{4'd0,  16'd0, 0, 1, 1, 1};
        vecs[3] = '{4'd12, 16'd1, 0, 8, 1, 8};
        vecs[4] = '{4'd3,  16'd3, 1, 3, 3, 9};
        vecs[5] = '{4'd8,  16'd2, 1, 8, 2, 16};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", smp.out_valid, 1'b0);
        check("rst_last", smp.out_last, 1'b0);
        check("rst_data", {smp.out_sin, smp.out_cos, smp.out_tone}, 23'd0);
        check("rst_clken", nco_clken_o, 1'b0);
        check("rst_ncorst", nco_reset_n_o, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        tick();
        check("rel_ncorst", nco_reset_n_o, 1'b1);
        check("rel_phi", nco_phi_inc_o, 32'd0);

        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_phi = tb_tab[i];
            tick();
        end
        cfg_we = 1'b0;
        tick();
        check("idle_phi", nco_phi_inc_o, tb_tab[0]);

        // Two-cycle NCO flush, then a single-sample sweep
        start_sweep(4'd1, 16'd1, 0);
        check("flush_busy", busy, 1'b1);
        check("flush_rst0", nco_reset_n_o, 1'b0);
        tick();
        check("flush_rst1", nco_reset_n_o, 1'b0);
        tick();
        check("flush_rel", nco_reset_n_o, 1'b1);
        wait_done("one");
        check_sweep("one", 1, 1, 1);

        for (int i = 0; i < 6; i++) begin
            start_sweep(vecs[i].nt, vecs[i].dw, vecs[i].rm);
            wait_done($sformatf("v%0d", i));
            check_sweep($sformatf("v%0d", i), vecs[i].ent, vecs[i].edw, vecs[i].exp_n);
        end

        // Abort after three samples, then a full sweep
        start_sweep(4'd2, 16'd4, 0);
        n = 0;
        while (got_q.size() < 3 && n < 200) begin
            @(negedge clk); n++;
        end
        check("abort_reach3", (got_q.size() >= 3), 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", smp.out_valid, 1'b0);
        check("abort_last", smp.out_last, 1'b0);
        check("abort_clken", nco_clken_o, 1'b0);
        repeat (6) tick();
        check("abort_nodone", done_cnt, 0);
        start_sweep(4'd2, 16'd4, 0);
        wait_done("post_abort");
        check_sweep("post_abort", 2, 4, 8);

        // Table write and start while busy are ignored
        start_sweep(4'd2, 16'd8, 1);
        repeat (4) tick();
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_phi = 32'hDEADBEEF;
        start = 1'b1; num_tones = 4'd1; dwell = 16'd1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        wait_done("busy_wr");
        check_sweep("busy_wr", 2, 8, 16);

        // Reset asserted mid-sweep while a sample is stalled
        start_sweep(4'd2, 16'd4, 2);
        n = 0;
        while (!smp.out_valid && n < 50) begin
            tick(); n++;
        end
        check("mid_valid", smp.out_valid, 1'b1);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_valid0", smp.out_valid, 1'b0);
        check("mid_data", {smp.out_sin, smp.out_cos, smp.out_tone, smp.out_last}, 24'd0);
        check("mid_clken", nco_clken_o, 1'b0);
        check("mid_ncorst", nco_reset_n_o, 1'b0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("mid_phi", nco_phi_inc_o, 32'd0);
        check("mid_nodone", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
